mat_job_ctrl: RTL and testbench

- Parametrised UART-side job controller for the NxN matrix multiplier. Receives framed jobs from the UART byte stream and loads the A and B operand matrices. Starts the multiplier, then streams the whole C result back over UART.
- Sits between the uart block (rx_byte/byte_available, tx_byte/tx handshake) and a mat_mul engine of matching N.

---
 rtl/mat_pkg.sv | 27 ++
 rtl/mat_job_ctrl_if.sv | 11 +
 rtl/mat_job_tx.sv | 128 ++++++++++++
 rtl/mat_job_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mat_job_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the UART-side matrix job controller: FSM encodings,
// error codes and framing bytes.
package mat_pkg;

  localparam logic [7:0] SYNC = 8'hFF;
  localparam logic [7:0] RESP = 8'hFE;
  localparam logic [7:0] NAK  = 8'hEE;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_JOB     = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_JOB_A, ST_LOAD_A, ST_JOB_B, ST_LOAD_B,
    ST_CHECK, ST_COMPUTE, ST_TX, ST_NAK
  } state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_HDR, TX_JOB, TX_DATA, TX_SUM
  } tx_phase_t;

  typedef enum logic [1:0] {
    HS_ISSUE, HS_WAIT_HI, HS_WAIT_LO
  } hs_t;

endpackage

// File: rtl/mat_job_ctrl_if.sv
// UART byte-stream interface between the job controller (master) and the uart block (slave).
interface mat_job_ctrl_if;
  logic [7:0] rx_byte;
  logic       byte_available;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;

  modport master (input rx_byte, byte_available, tx_busy, output tx_byte, tx_start);
  modport slave  (output rx_byte, byte_available, tx_busy, input tx_byte, tx_start);
endinterface

// File: rtl/mat_job_tx.sv
// Response serialiser: sends FE/job/result bytes (or EE/job as a NAK) over the UART
// handshake. MAT_JOB_CSUM_EN appends an XOR byte to full responses.
module mat_job_tx
  import mat_pkg::*;
#(
  parameter int N     = 2,
  parameter int RES_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   nak,
  input  logic [7:0]             job_id,
  input  logic [N*N*RES_W-1:0]   res,
  input  logic                   tx_busy,
  output logic [7:0]             tx_byte,
  output logic                   tx_start,
  output logic                   done
);
  localparam int NN    = N * N;
  localparam int BPE   = RES_W / 8;
  localparam int IDX_W = $clog2(NN + 1);
  localparam int BC_W  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam logic [IDX_W-1:0] LAST_E = IDX_W'(NN - 1);
  localparam logic [BC_W-1:0]  LAST_B = BC_W'(BPE - 1);

  tx_phase_t        phase, phase_n;
  hs_t              hs;
  logic             nak_q;
  logic [IDX_W-1:0] eidx;
  logic [BC_W-1:0]  bcnt;
  logic [7:0]       cur;
  logic             issue, adv;
  int unsigned      sel;
`ifdef MAT_JOB_CSUM_EN
  logic [7:0]       sum_q;
`endif

  // Byte selection: elements in index order, most significant byte first
  always_comb begin
    sel = 0;
    cur = 8'h00;
    case (phase)
      TX_HDR:  cur = nak_q ? NAK : RESP;
      TX_JOB:  cur = job_id;
      TX_DATA: begin
        sel = RES_W * int'(eidx) + 8 * (BPE - 1 - int'(bcnt));
        cur = res[sel +: 8];
      end
`ifdef MAT_JOB_CSUM_EN
      TX_SUM:  cur = sum_q;
`endif
      default: cur = 8'h00;
    endcase
  end

  always_comb begin
    phase_n = phase;
    issue   = 1'b0;
    adv     = 1'b0;
    if (phase != TX_IDLE) begin
      issue = (hs == HS_ISSUE) && !tx_busy && !tx_start;
      adv   = (hs == HS_WAIT_LO) && !tx_busy;
    end
    case (phase)
      TX_IDLE: if (start) phase_n = TX_HDR;
      TX_HDR:  if (adv) phase_n = TX_JOB;
      TX_JOB:  if (adv) phase_n = nak_q ? TX_IDLE : TX_DATA;
      TX_DATA: if (adv && eidx == LAST_E && bcnt == LAST_B)
`ifdef MAT_JOB_CSUM_EN
                 phase_n = TX_SUM;
`else
                 phase_n = TX_IDLE;
`endif
      TX_SUM:  if (adv) phase_n = TX_IDLE;
      default: phase_n = TX_IDLE;
    endcase
    done = adv && (phase_n == TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= TX_IDLE;
      hs       <= HS_ISSUE;
      nak_q    <= 1'b0;
      eidx     <= '0;
      bcnt     <= '0;
      tx_byte  <= 8'h00;
      tx_start <= 1'b0;
`ifdef MAT_JOB_CSUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      phase    <= phase_n;
      tx_start <= issue;
      if (phase == TX_IDLE && start) begin
        nak_q <= nak;
        eidx  <= '0;
        bcnt  <= '0;
        hs    <= HS_ISSUE;
`ifdef MAT_JOB_CSUM_EN
        sum_q <= 8'h00;
`endif
      end
      if (issue) begin
        tx_byte <= cur;
        hs      <= HS_WAIT_HI;
`ifdef MAT_JOB_CSUM_EN
        if (phase == TX_JOB || phase == TX_DATA) sum_q <= sum_q ^ cur;
`endif
      end
      if (hs == HS_WAIT_HI && tx_busy) hs <= HS_WAIT_LO;
      // A byte counts as accepted once busy has been seen high and then low
      if (adv) begin
        hs <= HS_ISSUE;
        if (phase == TX_DATA) begin
          if (bcnt == LAST_B) begin
            bcnt <= '0;
            eidx <= eidx + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mat_job_ctrl.sv
// UART-side job controller for the NxN matrix multiplier: frame parsing, operand
// loading, multiplier start and result return. MAT_JOB_CSUM_EN adds frame checksum and NAK.
module mat_job_ctrl
  import mat_pkg::*;
#(
  parameter int N       = 2,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 1200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mat_job_ctrl_if.master         uart,
  output logic [N*N*8-1:0]       mat_a,
  output logic [N*N*8-1:0]       mat_b,
  output logic                   mul_start,
  input  logic                   mul_done,
  input  logic [N*N*RES_W-1:0]   mat_c,
  output logic                   busy,
  output logic                   err_pulse,
  output logic [1:0]             err_code,
  output logic [7:0]             last_job
);
  localparam int NN    = N * N;
  localparam int IDX_W = $clog2(NN + 1);
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_E   = IDX_W'(NN - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

  state_t               state, state_n;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           job_id;
  logic [TW-1:0]        tcnt;
  logic [NN*RES_W-1:0]  res_q;
  logic                 bav, timed, tmo, abort, load_a, load_b;
  logic                 tx_go, tx_nak, tx_done;
  logic [1:0]           abort_code;
  logic [7:0]           rxb;
`ifdef MAT_JOB_CSUM_EN
  logic [7:0]           csum;
`endif

  assign bav  = uart.byte_available;
  assign rxb  = uart.rx_byte;
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    load_a     = 1'b0;
    load_b     = 1'b0;
    tx_go      = 1'b0;
    tx_nak     = 1'b0;
    timed      = state inside {ST_JOB_A, ST_LOAD_A, ST_JOB_B, ST_LOAD_B, ST_CHECK};
    tmo        = timed && !bav && (tcnt == TMO_LAST);
    case (state)
      ST_IDLE:   if (bav && rxb == SYNC) state_n = ST_JOB_A;
      ST_JOB_A:  if (bav) state_n = ST_LOAD_A;
      ST_LOAD_A: if (bav) begin
        load_a = 1'b1;
        if (idx == LAST_E) state_n = ST_JOB_B;
      end
      ST_JOB_B:  if (bav) begin
        if (rxb == job_id) state_n = ST_LOAD_B;
        else begin
          abort      = 1'b1;
          abort_code = ERR_JOB;
          state_n    = ST_IDLE;
        end
      end
      ST_LOAD_B: if (bav) begin
        load_b = 1'b1;
`ifdef MAT_JOB_CSUM_EN
        if (idx == LAST_E) state_n = ST_CHECK;
`else
        if (idx == LAST_E) state_n = ST_COMPUTE;
`endif
      end
`ifdef MAT_JOB_CSUM_EN
      ST_CHECK:  if (bav) begin
        if (rxb == csum) state_n = ST_COMPUTE;
        else begin
          abort      = 1'b1;
          abort_code = ERR_CSUM;
          tx_go      = 1'b1;
          tx_nak     = 1'b1;
          state_n    = ST_NAK;
        end
      end
`endif
      ST_COMPUTE: if (mul_done) begin
        tx_go   = 1'b1;
        state_n = ST_TX;
      end
      ST_TX, ST_NAK: if (tx_done) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    // tmo already excludes a byte arriving in the same cycle
    if (tmo) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
      state_n    = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      job_id    <= 8'h00;
      tcnt      <= '0;
      mat_a     <= '0;
      mat_b     <= '0;
      res_q     <= '0;
      mul_start <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
      last_job  <= 8'h00;
`ifdef MAT_JOB_CSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      mul_start <= (state_n == ST_COMPUTE) && (state != ST_COMPUTE);
      err_pulse <= abort;
      if (abort) err_code <= abort_code;
      if (!timed || bav || tmo) tcnt <= '0;
      else                      tcnt <= tcnt + 1'b1;
      if (state == ST_JOB_A && bav) begin
        job_id <= rxb;
        idx    <= '0;
`ifdef MAT_JOB_CSUM_EN
        csum   <= rxb;
`endif
      end
      if (load_a || load_b) begin
        if (load_a) mat_a[8*idx +: 8] <= rxb;
        else        mat_b[8*idx +: 8] <= rxb;
        idx <= (idx == LAST_E) ? '0 : idx + 1'b1;
`ifdef MAT_JOB_CSUM_EN
        csum <= csum ^ rxb;
`endif
      end
      if (state == ST_COMPUTE && mul_done) res_q <= mat_c;
      if (state == ST_TX && tx_done) begin
        last_job <= job_id;
        err_code <= ERR_NONE;
      end
    end
  end

  mat_job_tx #(.N(N), .RES_W(RES_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_go),
    .nak      (tx_nak),
    .job_id   (job_id),
    .res      (res_q),
    .tx_busy  (uart.tx_busy),
    .tx_byte  (uart.tx_byte),
    .tx_start (uart.tx_start),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_mat_job_ctrl.sv
// Self-checking bench for mat_job_ctrl with a UART transmitter model, a behavioural
// multiplier and a frame/response reference model. Honours MAT_JOB_CSUM_EN.
module tb_mat_job_ctrl;
  localparam int N       = 2;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 40;
  localparam int NN      = N * N;
  localparam int BPE     = RES_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mat_job_ctrl_if u_if ();
  logic [NN*8-1:0]     mat_a, mat_b;
  logic                mul_start, mul_done;
  logic [NN*RES_W-1:0] mat_c;
  logic                busy, err_pulse;
  logic [1:0]          err_code;
  logic [7:0]          last_job;

  mat_job_ctrl #(.N(N), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart      (u_if),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mat_c     (mat_c),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .last_job  (last_job)
  );

  int n_cmp = 0, n_bad = 0;
  int prot_err = 0, mul_cnt = 0, errp_cnt = 0;
  logic [7:0] txq[$], expq[$], fq[$];
  logic [7:0] a_m[NN], b_m[NN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART transmitter: busy rises the cycle after tx_start, falls a few cycles later
  initial begin : uart_model
    logic [7:0] b;
    u_if.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && u_if.tx_start) begin
        if (u_if.tx_busy) prot_err++;
        b = u_if.tx_byte;
        txq.push_back(b);
        @(posedge clk); #1;
        if (rst_n && u_if.tx_start) prot_err++;
        u_if.tx_busy = 1'b1;
        repeat ($urandom_range(5, 2)) begin
          @(posedge clk); #1;
          if (rst_n && (u_if.tx_byte !== b || u_if.tx_start)) prot_err++;
        end
        u_if.tx_busy = 1'b0;
      end
    end
  end

  // Multiplier: C = A*B truncated to RES_W, done three cycles after start
  initial begin : mul_model
    int acc;
    mul_done = 1'b0;
    mat_c    = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mul_start) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            acc = 0;
            for (int k = 0; k < N; k++)
              acc += int'(mat_a[8*(r*N+k) +: 8]) * int'(mat_b[8*(k*N+c) +: 8]);
            mat_c[RES_W*(r*N+c) +: RES_W] = acc[RES_W-1:0];
          end
        repeat (3) @(posedge clk);
        #1 mul_done = 1'b1;
        @(posedge clk); #1;
        mul_done = 1'b0;
      end
    end
  end

  initial begin : event_counter
    forever begin
      @(posedge clk); #1;
      if (mul_start) mul_cnt++;
      if (err_pulse) errp_cnt++;
    end
  end

  function automatic logic [NN*8-1:0] pack(input logic [7:0] m[NN]);
    logic [NN*8-1:0] v;
    for (int i = 0; i < NN; i++) v[8*i +: 8] = m[i];
    return v;
  endfunction

  function automatic void build_expect(input logic [7:0] job);
    logic [7:0] x;
    int acc;
    logic [RES_W-1:0] e;
    expq.delete();
    expq.push_back(8'hFE);
    expq.push_back(job);
    x = job;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(a_m[r*N+k]) * int'(b_m[k*N+c]);
        e = acc[RES_W-1:0];
        for (int i = BPE - 1; i >= 0; i--) begin
          expq.push_back(e[8*i +: 8]);
          x ^= e[8*i +: 8];
        end
      end
`ifdef MAT_JOB_CSUM_EN
    expq.push_back(x);
`endif
  endfunction

  function automatic void build_frame(input logic [7:0] job, input logic [7:0] job_b,
                                      input logic [7:0] flip);
    logic [7:0] cs;
    cs = job;
    fq.delete();
    fq.push_back(8'hFF);
    fq.push_back(job);
    for (int i = 0; i < NN; i++) begin fq.push_back(a_m[i]); cs ^= a_m[i]; end
    fq.push_back(job_b);
    for (int i = 0; i < NN; i++) begin fq.push_back(b_m[i]); cs ^= b_m[i]; end
`ifdef MAT_JOB_CSUM_EN
    fq.push_back(cs ^ flip);
`else
    cs = flip;
`endif
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    u_if.rx_byte = b;
    u_if.byte_available = 1'b1;
    @(negedge clk);
    u_if.byte_available = 1'b0;
    u_if.rx_byte = 8'($urandom);
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send(fq[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  task automatic randomize_mats(input int ff_chance);
    for (int i = 0; i < NN; i++) begin
      a_m[i] = ($urandom_range(ff_chance, 1) == 1) ? 8'hFF : 8'($urandom);
      b_m[i] = ($urandom_range(ff_chance, 1) == 1) ? 8'hFF : 8'($urandom);
    end
  endtask

  task automatic run_good(input logic [7:0] job, input string tag);
    int m0;
    m0 = mul_cnt;
    txq.delete();
    build_expect(job);
    build_frame(job, job, 8'h00);
    send_n(fq.size());
    send(8'hFF);
    wait_idle(tag);
    check({tag, ".mul_starts"}, 64'(mul_cnt - m0), 64'd1);
    check({tag, ".rsp_len"}, 64'(txq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < txq.size(); i++)
      check($sformatf("%s.rsp%0d", tag, i), 64'(txq[i]), 64'(expq[i]));
    check({tag, ".mat_a"}, 64'(mat_a), 64'(pack(a_m)));
    check({tag, ".mat_b"}, 64'(mat_b), 64'(pack(b_m)));
    check({tag, ".last_job"}, 64'(last_job), 64'(job));
    check({tag, ".err_code"}, 64'(err_code), 64'd0);
  endtask

  initial begin : main
    int e0, m0;
    u_if.rx_byte = 8'h00;
    u_if.byte_available = 1'b0;

    repeat (4) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.tx_start", 64'(u_if.tx_start), 64'd0);
    check("rst.tx_byte", 64'(u_if.tx_byte), 64'd0);
    check("rst.mul_start", 64'(mul_start), 64'd0);
    check("rst.err_pulse", 64'(err_pulse), 64'd0);
    check("rst.err_code", 64'(err_code), 64'd0);
    check("rst.last_job", 64'(last_job), 64'd0);
    check("rst.mat_a", 64'(mat_a), 64'd0);
    check("rst.mat_b", 64'(mat_b), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference job: C = [19,22,43,50]
    a_m = '{8'd1, 8'd2, 8'd3, 8'd4};
    b_m = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_good(8'h07, "ref");
    check("ref.mat_a_const", 64'(mat_a), 64'h04030201);
    check("ref.c3_lo", (txq.size() > 9) ? 64'(txq[9]) : 64'hDEAD, 64'h32);

    // Job ID mismatch
    randomize_mats(8);
    build_frame(8'h09, 8'h08, 8'h00);
    e0 = errp_cnt; m0 = mul_cnt;
    txq.delete();
    send_n(3 + NN);
    repeat (3) @(negedge clk);
    check("jobid.err_code", 64'(err_code), 64'd2);
    check("jobid.err_pulses", 64'(errp_cnt - e0), 64'd1);
    check("jobid.busy", 64'(busy), 64'd0);
    check("jobid.tx_count", 64'(txq.size()), 64'd0);
    check("jobid.mul_starts", 64'(mul_cnt - m0), 64'd0);
    check("jobid.last_job", 64'(last_job), 64'h07);

    // Reset while streaming result data
    randomize_mats(8);
    build_frame(8'h21, 8'h21, 8'h00);
    txq.delete();
    send_n(fq.size());
    for (int i = 0; i < 3000 && txq.size() < 4; i++) @(negedge clk);
    check("rstx.reached_data", 64'(txq.size() >= 4), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstx.busy", 64'(busy), 64'd0);
    check("rstx.tx_start", 64'(u_if.tx_start), 64'd0);
    check("rstx.tx_byte", 64'(u_if.tx_byte), 64'd0);
    check("rstx.err_code", 64'(err_code), 64'd0);
    check("rstx.last_job", 64'(last_job), 64'd0);
    check("rstx.mat_a", 64'(mat_a), 64'd0);
    check("rstx.mat_b", 64'(mat_b), 64'd0);
    check("rstx.mul_start", 64'(mul_start), 64'd0);
    check("rstx.err_pulse", 64'(err_pulse), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rstx.tx_start_hold", 64'(u_if.tx_start), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstx.after_busy", 64'(busy), 64'd0);
    txq.delete();

    // Inter-byte timeout after the third A byte
    randomize_mats(8);
    build_frame(8'h0A, 8'h0A, 8'h00);
    e0 = errp_cnt;
    send_n(5);
    repeat (TIMEOUT - 5) @(negedge clk);
    check("tmo.not_yet_busy", 64'(busy), 64'd1);
    check("tmo.not_yet_err", 64'(errp_cnt - e0), 64'd0);
    repeat (10) @(negedge clk);
    check("tmo.err_code", 64'(err_code), 64'd1);
    check("tmo.busy", 64'(busy), 64'd0);
    check("tmo.err_pulses", 64'(errp_cnt - e0), 64'd1);
    check("tmo.tx_count", 64'(txq.size()), 64'd0);
    randomize_mats(8);
    run_good(8'($urandom), "after_tmo");

    // Sync byte inside the payload is data
    randomize_mats(1000);
    a_m[1] = 8'hFF;
    run_good(8'h33, "ffdata");
    check("ffdata.elem1", 64'(mat_a[15:8]), 64'hFF);

    for (int j = 0; j < 5; j++) begin
      randomize_mats(6);
      run_good(8'($urandom), $sformatf("rnd%0d", j));
    end

`ifdef MAT_JOB_CSUM_EN
    // Wrong checksum: NAK then idle
    randomize_mats(8);
    build_frame(8'h07, 8'h07, 8'h5A);
    e0 = errp_cnt; m0 = mul_cnt;
    txq.delete();
    send_n(fq.size());
    wait_idle("csum");
    check("csum.err_code", 64'(err_code), 64'd3);
    check("csum.err_pulses", 64'(errp_cnt - e0), 64'd1);
    check("csum.mul_starts", 64'(mul_cnt - m0), 64'd0);
    check("csum.nak_len", 64'(txq.size()), 64'd2);
    check("csum.nak0", (txq.size() > 0) ? 64'(txq[0]) : 64'hDEAD, 64'hEE);
    check("csum.nak1", (txq.size() > 1) ? 64'(txq[1]) : 64'hDEAD, 64'h07);
`endif

    repeat (10) @(negedge clk);
    check("protocol_violations", 64'(prot_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
